// File: rtl/load_store_unit_if.sv
// Request/response and data_memory word-port signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the surrounding core and memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_A;
  logic [31:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_WD, mem_A
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_WE, mem_WD, mem_A
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for the data_memory word port: sub-word loads by lane
// extraction, sub-word stores by read-modify-write, one response per accepted request.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the
// requester holds its fields stable until then. resp_valid is a one-cycle pulse with no
// back-pressure, and resp_rdata/resp_err stay valid until the next transfer.
module load_store_unit #(
  parameter int DATA_MEMORY_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      bus,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        req_err;

  function automatic logic calc_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = (addr[1:0] != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | addr[0];
      default: bad = 1'b1;
    endcase
    if (word_idx >= 32'(DATA_MEMORY_DEPTH)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lane,
                                          input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rd[{lane, 3'b000} +: 8];
    h = lane[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = rd;
    endcase
    return res;
  endfunction

  // Only SB and SH reach the merge; SW goes straight to WRITE with the raw data.
  function automatic logic [31:0] merge(input logic [2:0] f3, input logic [1:0] lane,
                                        input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] res;
    res = old;
    if (f3 == 3'b000) res[{lane, 3'b000} +: 8] = wd[7:0];
    else if (lane[1]) res[31:16] = wd[15:0];
    else res[15:0] = wd[15:0];
    return res;
  endfunction

  assign bus.req_ready  = (state == IDLE) && rst_n;
  assign accept         = bus.req_valid && bus.req_ready;
  assign req_err        = calc_err(bus.req_we, bus.req_funct3, bus.req_addr);

  assign bus.mem_A      = (state != IDLE) ? {2'b00, addr_q[31:2]} : 32'd0;
  assign bus.mem_WE     = (state == WRITE);
  assign bus.mem_WD     = wdata_q;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign state_dbg      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                                    state_nxt = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_nxt = WRITE;
          else                                            state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 32'd0;
            err_q    <= req_err;
          end
        end
        READ: begin
          if (we_q) wdata_q <= merge(funct3_q, addr_q[1:0], bus.mem_RD, wdata_q);
          else      rdata_q <= extract(funct3_q, addr_q[1:0], bus.mem_RD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table through a response scoreboard,
// plus hand-written reset-during-WRITE and back-to-back sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  state_dbg;
  logic [31:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          acc_cnt = 0;
  int          resp_cnt = 0;
  logic [32:0] exp_q[$];

  load_store_unit_if bus ();

  load_store_unit #(.DATA_MEMORY_DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // Clock / reset block and attached word memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_RD = mem[bus.mem_A[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_WE) begin
      mem[bus.mem_A[7:0]] <= bus.mem_WD;
      we_cnt <= we_cnt + 1;
    end
    if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Driver: one request, scoreboard push at accept, pop/compare at response.
  task automatic do_req(input string name, input vec_t v);
    int n;
    int we0;
    logic [32:0] e;
    @(negedge clk);
    wait_ready(name);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    we0 = we_cnt;
    @(posedge clk);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    n = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
      n++;
      if (n == 1) chk({name, "_mem_A"}, bus.mem_A, {2'b00, v.addr[31:2]});
    end while (!bus.resp_valid && n < 10);
    if (!bus.resp_valid) begin
      chk({name, "_resp_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      chk({name, "_latency"}, 32'(n), 32'(v.exp_lat));
      chk({name, "_rdata"}, bus.resp_rdata, e[31:0]);
      chk({name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e[32]});
      if (e[32]) chk({name, "_no_write"}, 32'(we_cnt - we0), 32'd0);
    end
  endtask

  initial begin
    int acc0, resp0, sent, got, last;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    logic [32:0] e;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0]  = 32'hA5A5A5A5;
    mem[8]  = 32'h12345678;
    mem[12] = 32'h11223344;
    mem[20] = 32'h0000AAAA;
    mem[21] = 32'h0000BBBB;
    mem[22] = 32'h0000CCCC;

    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_mem_WE", {31'd0, bus.mem_WE}, 32'd0);
    chk("rst_mem_WD", bus.mem_WD, 32'd0);
    chk("rst_mem_A", bus.mem_A, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);

    tbl.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2));
    tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2));
    tbl.push_back(mk(1, 3'b000, 32'h22,  32'h55AA11AB, 32'h0,        0, 3));
    tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'h12AB5678, 0, 2));
    tbl.push_back(mk(0, 3'b000, 32'h22,  32'h0,        32'hFFFFFFAB, 0, 2));
    tbl.push_back(mk(0, 3'b100, 32'h22,  32'h0,        32'h000000AB, 0, 2));
    tbl.push_back(mk(0, 3'b000, 32'h23,  32'h0,        32'h00000012, 0, 2));
    tbl.push_back(mk(0, 3'b101, 32'h20,  32'h0,        32'h00005678, 0, 2));
    tbl.push_back(mk(1, 3'b001, 32'h26,  32'hFFFF8001, 32'h0,        0, 3));
    tbl.push_back(mk(0, 3'b001, 32'h26,  32'h0,        32'hFFFF8001, 0, 2));
    tbl.push_back(mk(0, 3'b101, 32'h26,  32'h0,        32'h00008001, 0, 2));
    tbl.push_back(mk(0, 3'b010, 32'h24,  32'h0,        32'h80010000, 0, 2));
    tbl.push_back(mk(0, 3'b010, 32'h2,   32'h0,        32'h0,        1, 1));
    tbl.push_back(mk(0, 3'b001, 32'h1,   32'h0,        32'h0,        1, 1));
    tbl.push_back(mk(0, 3'b011, 32'h0,   32'h0,        32'h0,        1, 1));
    tbl.push_back(mk(1, 3'b000, 32'h400, 32'h77,       32'h0,        1, 1));
    tbl.push_back(mk(1, 3'b100, 32'h8,   32'h77,       32'h0,        1, 1));
    tbl.push_back(mk(1, 3'b010, 32'h3FC, 32'h01020304, 32'h0,        0, 2));
    tbl.push_back(mk(0, 3'b010, 32'h3FC, 32'h0,        32'h01020304, 0, 2));
    tbl.push_back(mk(0, 3'b010, 32'h400, 32'h0,        32'h0,        1, 1));

    for (int i = 0; i < tbl.size(); i++) do_req($sformatf("vec%0d", i), tbl[i]);

    chk("mem_word_0x10", mem[4], 32'hDEADBEEF);
    chk("mem_sb_0x22", mem[8], 32'h12AB5678);
    chk("mem_sh_0x26", mem[9], 32'h80010000);
    chk("mem_err_untouched", mem[0], 32'hA5A5A5A5);
    chk("mem_sb_bad_funct3", mem[2], 32'h0);

    for (int i = 0; i < 6; i++) begin
      int idx;
      logic [31:0] d;
      idx = $urandom_range(40, 250);
      d = $urandom;
      do_req($sformatf("rnd_sw%0d", i), mk(1, 3'b010, 32'(idx * 4), d, 32'h0, 0, 2));
      chk($sformatf("rnd_mem%0d", i), mem[idx], d);
      do_req($sformatf("rnd_lw%0d", i), mk(0, 3'b010, 32'(idx * 4), 32'h0, d, 0, 2));
    end

    // Reset in the WRITE cycle of an SB: no write, no response.
    @(negedge clk);
    wait_ready("rstw");
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h31; bus.req_wdata = 32'hEE;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    resp0 = resp_cnt;
    @(negedge clk);
    chk("rstw_in_write", {30'd0, state_dbg}, 32'd2);
    chk("rstw_we_before", {31'd0, bus.mem_WE}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_dropped", {31'd0, bus.mem_WE}, 32'd0);
    chk("rstw_state_idle", {30'd0, state_dbg}, 32'd0);
    chk("rstw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rstw_mem_kept", mem[12], 32'h11223344);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rstw_no_resp", 32'(resp_cnt - resp0), 32'd0);

    // Back-to-back LWs with req_valid held high.
    b2b_addr[0] = 32'h50; b2b_addr[1] = 32'h54; b2b_addr[2] = 32'h58;
    b2b_data[0] = 32'h0000AAAA; b2b_data[1] = 32'h0000BBBB; b2b_data[2] = 32'h0000CCCC;
    acc0 = acc_cnt; sent = 0; got = 0; last = 0;
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    @(negedge clk);
    for (int k = 0; k < 40 && got < 3; k++) begin
      if (sent == 3) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        e = exp_q.pop_front();
        chk($sformatf("b2b_rdata%0d", got), bus.resp_rdata, e[31:0]);
        if (got > 0) chk($sformatf("b2b_gap%0d", got), 32'(cyc - last), 32'd3);
        last = cyc;
        got++;
      end
      if (bus.req_ready && sent < 3) begin
        bus.req_valid = 1'b1;
        bus.req_addr  = b2b_addr[sent];
        exp_q.push_back({1'b0, b2b_data[sent]});
        sent++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_resp_count", 32'(got), 32'd3);
    repeat (4) @(negedge clk);
    chk("b2b_accepts", 32'(acc_cnt - acc0), 32'd3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the `data_memory` word port. It accepts one load or store request at a time from the execute stage and converts the byte address into a word index. It performs RV32I sub-word access: LB, LH, LW, LBU, LHU, SB, SH and SW. Sub-word stores are done as read-modify-write, because `data_memory` only writes full words. The unit also detects misaligned, illegal and out-of-range requests and returns a single response per request.

## Interface
Parameters:
- `DATA_MEMORY_DEPTH`, default 256: number of 32-bit words in the attached memory. Legal word index is 0 to DATA_MEMORY_DEPTH-1.

Ports:
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE with `rst_n` high.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low bits for sub-word stores.
- `resp_valid`  out  1  one-cycle pulse that completes the request.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  request was rejected and memory was not accessed.
- `mem_WE`  out  1  write enable to `data_memory`.
- `mem_WD`  out  32  write data to `data_memory`.
- `mem_A`  out  32  word index: {2'b00, addr[31:2]}.
- `mem_RD`  in  32  combinational read data from `data_memory`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- **Accept:** a request is accepted when `req_valid` and `req_ready` are both high at a clock edge. On accept, latch we, funct3, addr and wdata, and compute the error flag.
- **Error conditions:**
  - funct3 is 011, 110 or 111 (for stores, also 100 and 101).
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - addr[31:2] >= DATA_MEMORY_DEPTH.
- **Transitions:**
  - IDLE → RESP on an error.
  - IDLE → READ on a load or a sub-word store.
  - IDLE → WRITE on SW.
  - READ → RESP for a load: capture the extracted data into `resp_rdata`.
  - READ → WRITE for SB/SH: capture the merged word into the write-data register.
  - WRITE → RESP.
  - RESP → IDLE.
- **Load extraction:** byte lane = addr[1:0], half lane = addr[1].
  - LB/LH sign-extend the selected byte or halfword.
  - LBU/LHU zero-extend it.
  - LW passes the word through unchanged.
- **Store merge:**
  - SB replaces bits 8*lane+7 down to 8*lane of the old word with wdata[7:0].
  - SH replaces the half selected by addr[1] with wdata[15:0].
  - SW writes wdata as is.
- **Memory port drive:**
  - `mem_A` is driven from the latched address in every state other than IDLE.
  - `mem_WE` = 1 only in WRITE (decoded from state).
  - `mem_WD` is held stable for the whole WRITE cycle.
- **Response outputs:** `resp_valid` = 1 only in RESP. `resp_rdata` and `resp_err` hold their values from RESP until the next accept.

## Timing
- Reset values: state IDLE, `req_ready` 0 while `rst_n` is low, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `mem_WE` 0, `mem_WD` 0, `mem_A` 0.
- Latency from the accept edge at cycle T to `resp_valid` high:
  - error: T+1
  - load: T+2 (READ in T+1)
  - SW: T+2 (WRITE in T+1)
  - SB/SH: T+3 (READ T+1, WRITE T+2)
- The memory write takes effect on the clock edge that ends the WRITE cycle.
- **Throughput:** `req_ready` is low from the cycle after accept until back in IDLE. Back-to-back accepts are therefore spaced by latency+1.
- **No combinational path:** `req_valid` has no combinational path to any mem_* output or to `resp_*`.
- **Reset mid-operation:** asserting `rst_n` low forces IDLE immediately and drops `mem_WE` asynchronously. If this happens before the end of WRITE, memory is unchanged and no response is issued.
- **Unaccepted requests:** request fields are ignored whenever `req_ready` is low.

## Test plan
- **Word round trip:** SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → `resp_rdata` 0xDEADBEEF; store `resp_valid` at accept+2; `mem_A` = 4.
- **Byte store and load:** word 0x12345678 at 0x20; SB addr 0x22 data 0xAB → word becomes 0x12AB5678. Then:
  - LB 0x22 → 0xFFFFFFAB
  - LBU 0x22 → 0x000000AB
  - SB response at accept+3.
- **Halfword store and load:** SH addr 0x26 data 0x8001 onto 0x00000000 → word 0x80010000. Then LH 0x26 → 0xFFFF8001 and LHU 0x26 → 0x00008001.
- **Error cases:** each of the following → `resp_err` 1 at accept+1, `mem_WE` never high, memory unchanged:
  - LW 0x0000_0002
  - LH 0x0000_0001
  - funct3 011
  - SB 0x0000_0400 with depth 256
- **Reset during WRITE:** issue SB, pull `rst_n` low during the WRITE cycle → `mem_WE` drops within the same cycle, target word keeps its old value, `resp_valid` stays 0, `req_ready` is 1 after release.
- **Back-to-back requests:** `req_valid` held high with 3 LWs → exactly one accept per IDLE visit, responses 3 cycles apart, in order.
